// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response and dmem bus bundle
// slave = load/store unit, master = core plus memory side
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [1:0]  req_off;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned,
      input  req_addr, req_off, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_rw, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned,
      output req_addr, req_off, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store sequencer for dmem
// big-endian lanes, sub-word stores done as read-modify-write
module dmem_lsu (
   input  logic       clk,
   input  logic       reset,
   dmem_lsu_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

   state_t      state;
   logic        we_q;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic        req_err;
   logic [7:0]  lane8;
   logic [15:0] lane16;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign bus.req_ready = (state == IDLE);

   assign req_err = (bus.req_size == 2'b11)
                 || (bus.req_size == 2'b01 && bus.req_off[0])
                 || (bus.req_size == 2'b10 && bus.req_off != 2'b00);

   // pick the addressed lane of the read word and extend it
   always_comb begin
      lane8 = bus.mem_rdata[7:0];
      unique case (off_q)
         2'd0: lane8 = bus.mem_rdata[31:24];
         2'd1: lane8 = bus.mem_rdata[23:16];
         2'd2: lane8 = bus.mem_rdata[15:8];
         2'd3: lane8 = bus.mem_rdata[7:0];
      endcase
      lane16 = off_q[1] ? bus.mem_rdata[15:0]
                        : bus.mem_rdata[31:16];
      load_val = bus.mem_rdata;
      unique case (size_q)
         2'b00: load_val = uns_q ? {24'h0, lane8}
                                 : {{24{lane8[7]}}, lane8};
         2'b01: load_val = uns_q ? {16'h0, lane16}
                                 : {{16{lane16[15]}}, lane16};
         default: load_val = bus.mem_rdata;
      endcase
   end

   // splice the store data into the old word for RMW
   always_comb begin
      merged = bus.mem_rdata;
      if (size_q == 2'b00) begin
         unique case (off_q)
            2'd0: merged[31:24] = wdata_q[7:0];
            2'd1: merged[23:16] = wdata_q[7:0];
            2'd2: merged[15:8]  = wdata_q[7:0];
            2'd3: merged[7:0]   = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merged[15:0] = wdata_q;
      end else begin
         merged[31:16] = wdata_q;
      end
   end

   // sequencer FSM with registered memory and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         size_q        <= 2'b00;
         off_q         <= 2'b00;
         wdata_q       <= 16'h0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= 32'h0;
         bus.mem_rw    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_wdata <= 32'h0;
      end else begin
         bus.rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (req_err) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= 32'h0;
                  end else begin
                     we_q         <= bus.req_we;
                     uns_q        <= bus.req_unsigned;
                     size_q       <= bus.req_size;
                     off_q        <= bus.req_off;
                     wdata_q      <= bus.req_wdata[15:0];
                     bus.mem_addr <= bus.req_addr;
                     if (bus.req_we && bus.req_size == 2'b10) begin
                        bus.mem_wdata <= bus.req_wdata;
                        bus.mem_rw    <= 1'b1;
                        state         <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: state <= RDW;
            RDW: begin
               if (we_q) begin
                  bus.mem_wdata <= merged;
                  bus.mem_rw    <= 1'b1;
                  state         <= WR;
               end else begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= load_val;
                  state         <= IDLE;
               end
            end
            WR: begin
               bus.mem_rw    <= 1'b0;
               bus.rsp_valid <= 1'b1;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= 32'h0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random checks of dmem_lsu
// against a byte-level reference model and a behavioural dmem
module tb_dmem_lsu;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_lsu_if bif ();
   dmem_lsu dut (.clk(clk), .reset(reset), .bus(bif));

   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   int n_assert = 0;
   int n_fail = 0;

   // synchronous-read memory standing in for dmem
   always @(posedge clk) begin
      if (bif.mem_rw) mem[bif.mem_addr[3:0]] <= bif.mem_wdata;
      bif.mem_rdata <= mem[bif.mem_addr[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(input int sz, input int off);
      return sz == 3 || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w,
      input int sz, input bit uns, input int off);
      int unsigned b[4];
      int unsigned v;
      for (int i = 0; i < 4; i++) b[i] = (w >> (8 * (3 - i))) & 32'hFF;
      if (sz == 0) begin
         v = b[off];
         if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = b[off] * 256 + b[off + 1];
         if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w,
      input int sz, input logic [31:0] wd, input int off);
      int unsigned b[4];
      if (sz == 2) return wd;
      for (int i = 0; i < 4; i++) b[i] = (w >> (8 * (3 - i))) & 32'hFF;
      if (sz == 0) begin
         b[off] = wd & 32'hFF;
      end else begin
         b[off] = (wd >> 8) & 32'hFF;
         b[off + 1] = wd & 32'hFF;
      end
      return (b[0] << 24) + (b[1] << 16) + (b[2] << 8) + b[3];
   endfunction

   task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
      input logic [31:0] addr, input logic [1:0] off, input logic [31:0] wd);
      bif.req_we = we;
      bif.req_size = sz;
      bif.req_unsigned = uns;
      bif.req_addr = addr;
      bif.req_off = off;
      bif.req_wdata = wd;
   endtask

   task automatic access(input string tag, input bit we, input logic [1:0] sz,
      input bit uns, input logic [31:0] addr, input logic [1:0] off,
      input logic [31:0] wd, output logic [31:0] got);
      int lat, nrw, exp_lat, idx;
      bit err;
      logic [31:0] exp_rd;
      idx = int'(addr[3:0]);
      err = is_err(int'(sz), int'(off));
      exp_rd = 32'h0;
      if (err) exp_lat = 1;
      else if (we) exp_lat = (sz == 2'b10) ? 2 : 4;
      else begin
         exp_lat = 3;
         exp_rd = ref_load(ref_mem[idx], int'(sz), uns, int'(off));
      end
      @(negedge clk);
      drive(we, sz, uns, addr, off, wd);
      bif.req_valid = 1'b1;
      chk({tag, ".ready_in"}, {31'h0, bif.req_ready}, 32'h1);
      @(posedge clk);
      #1 bif.req_valid = 1'b0;
      lat = 0;
      nrw = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (bif.mem_rw) nrw++;
         if (bif.rsp_valid) break;
         chk({tag, ".busy"}, {31'h0, bif.req_ready}, 32'h0);
      end
      got = bif.rsp_rdata;
      chk({tag, ".lat"}, lat, exp_lat);
      chk({tag, ".err"}, {31'h0, bif.rsp_err}, {31'h0, err});
      chk({tag, ".rdata"}, bif.rsp_rdata, exp_rd);
      chk({tag, ".nwr"}, nrw, (we && !err) ? 1 : 0);
      chk({tag, ".ready_out"}, {31'h0, bif.req_ready}, 32'h1);
      if (!err) begin
         if (we) ref_mem[idx] = ref_store(ref_mem[idx], int'(sz), wd, int'(off));
         chk({tag, ".addr"}, bif.mem_addr, addr);
         chk({tag, ".mem"}, mem[idx], ref_mem[idx]);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".ready"}, {31'h0, bif.req_ready}, 32'h1);
      chk({tag, ".rsp_valid"}, {31'h0, bif.rsp_valid}, 32'h0);
      chk({tag, ".rsp_err"}, {31'h0, bif.rsp_err}, 32'h0);
      chk({tag, ".rsp_rdata"}, bif.rsp_rdata, 32'h0);
      chk({tag, ".mem_rw"}, {31'h0, bif.mem_rw}, 32'h0);
      chk({tag, ".mem_addr"}, bif.mem_addr, 32'h0);
      chk({tag, ".mem_wdata"}, bif.mem_wdata, 32'h0);
   endtask

   initial begin
      logic [31:0] got, a, d;
      int lat, nrw;
      bit we, uns;
      logic [1:0] sz, off;

      reset = 1'b1;
      bif.req_valid = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;

      access("wst", 1'b1, 2'b10, 1'b0, 32'h5, 2'd0, 32'h11223344, got);
      access("wld", 1'b0, 2'b10, 1'b0, 32'h5, 2'd0, 32'h0, got);
      chk("wld.const", got, 32'h11223344);

      access("bst", 1'b1, 2'b00, 1'b0, 32'h5, 2'd1, 32'hA5, got);
      chk("bst.const", mem[5], 32'h11A53344);

      access("pre", 1'b1, 2'b10, 1'b0, 32'h9, 2'd0, 32'h80FF7F01, got);
      access("lbs", 1'b0, 2'b00, 1'b0, 32'h9, 2'd0, 32'h0, got);
      chk("lbs.const", got, 32'hFFFFFF80);
      access("lbu", 1'b0, 2'b00, 1'b1, 32'h9, 2'd0, 32'h0, got);
      chk("lbu.const", got, 32'h00000080);
      access("lhs", 1'b0, 2'b01, 1'b0, 32'h9, 2'd2, 32'h0, got);
      chk("lhs.const", got, 32'h00007F01);

      access("e_half", 1'b0, 2'b01, 1'b0, 32'h9, 2'd1, 32'h0, got);
      access("e_word", 1'b1, 2'b10, 1'b0, 32'h9, 2'd2, 32'hDEAD, got);
      access("e_size", 1'b0, 2'b11, 1'b0, 32'h9, 2'd0, 32'h0, got);
      chk("e.mem", mem[9], 32'h80FF7F01);

      // reset in the RDW cycle of a byte store
      @(negedge clk);
      drive(1'b1, 2'b00, 1'b0, 32'h5, 2'd2, 32'h77);
      bif.req_valid = 1'b1;
      @(posedge clk);
      #1 bif.req_valid = 1'b0;
      nrw = 0;
      @(negedge clk);
      if (bif.mem_rw) nrw++;
      @(negedge clk);
      if (bif.mem_rw) nrw++;
      reset = 1'b1;
      @(negedge clk);
      if (bif.mem_rw) nrw++;
      chk_reset_vals("rst_rdw");
      reset = 1'b0;
      chk("rst_rdw.nwr", nrw, 0);
      chk("rst_rdw.mem", mem[5], 32'h11A53344);
      access("rst_ld", 1'b0, 2'b10, 1'b0, 32'h5, 2'd0, 32'h0, got);

      // store with a load queued behind it
      @(negedge clk);
      drive(1'b1, 2'b10, 1'b0, 32'h3, 2'd0, 32'hCAFEF00D);
      bif.req_valid = 1'b1;
      @(posedge clk);
      #1 drive(1'b0, 2'b10, 1'b0, 32'h3, 2'd0, 32'h0);
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (bif.rsp_valid) break;
         chk("b2b.busy1", {31'h0, bif.req_ready}, 32'h0);
      end
      chk("b2b.lat1", lat, 2);
      chk("b2b.ready1", {31'h0, bif.req_ready}, 32'h1);
      @(posedge clk);
      #1 bif.req_valid = 1'b0;
      ref_mem[3] = 32'hCAFEF00D;
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (bif.rsp_valid) break;
         chk("b2b.busy2", {31'h0, bif.req_ready}, 32'h0);
      end
      chk("b2b.lat2", lat, 3);
      chk("b2b.rdata", bif.rsp_rdata, 32'hCAFEF00D);

      // random traffic over all 16 modelled words
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         a[3:0] = i[3:0];
         access("rinit", 1'b1, 2'b10, 1'b0, a, 2'd0, $urandom, got);
      end
      for (int i = 0; i < 80; i++) begin
         a = $urandom;
         d = $urandom;
         we = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         off = 2'($urandom_range(0, 3));
         access("rnd", we, sz, uns, a, off, d, got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
